// File: rtl/rd_stream_pkg.sv
// Shared types for the read-streaming engine: FSM state encoding and
// memory-port opcode constants.
package rd_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic MEM_OP_RD = 1'b0;
  localparam logic MEM_OP_WR = 1'b1;

  // Occupancy counter width for a FIFO of the given depth (holds 0..depth).
  function automatic int unsigned fifo_cnt_bits(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rd_stream_if.sv
// Memory read port plus output stream of the read-streaming engine.
//   mem_req_*    : read burst request (no ready; accepted when valid)
//   mem_rd_*     : returned read beats, valid/ready
//   out_*        : fetched words toward the datapath, valid/ready
// master = the engine, slave = memory model / consumer side.
interface rd_stream_if #(
  parameter int unsigned MEM_LEN_BITS  = 8,
  parameter int unsigned MEM_ADDR_BITS = 32,
  parameter int unsigned MEM_DATA_BITS = 64
);

  logic                     mem_req_valid;
  logic                     mem_req_opcode;
  logic [MEM_LEN_BITS-1:0]  mem_req_len;
  logic [MEM_ADDR_BITS-1:0] mem_req_addr;
  logic                     mem_rd_valid;
  logic [MEM_DATA_BITS-1:0] mem_rd_bits;
  logic                     mem_rd_ready;
  logic                     out_valid;
  logic [MEM_DATA_BITS-1:0] out_data;
  logic                     out_ready;

  modport master (
    output mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
    output mem_rd_ready, out_valid, out_data,
    input  mem_rd_valid, mem_rd_bits, out_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
    input  mem_rd_ready, out_valid, out_data,
    output mem_rd_valid, mem_rd_bits, out_ready
  );

endinterface

// File: rtl/rd_stream_fifo.sv
// rd_fifo: synchronous FIFO with registered occupancy/flags and a
// fall-through head (rdata_o always shows the oldest entry).
//   clk_i, rst_i        : clock, synchronous active-high flush
//   push_i, wdata_i     : write one entry
//   pop_i               : remove head (ignored when empty)
//   rdata_o             : current head
//   full_o, empty_o     : occupancy flags
//   count_o             : number of stored entries
module rd_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             push_en, pop_en;

  // A push at full is only taken when a pop frees the slot in the same cycle.
  assign pop_en  = pop_i && !empty_q;
  assign push_en = push_i && (!full_q || pop_en);

  always_comb begin
    count_d = count_q;
    if (push_en && !pop_en)      count_d = count_q + CW'(1);
    else if (!push_en && pop_en) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/rd_stream.sv
// rd_stream: fetches `length` consecutive memory words from `base_addr` in
// bursts of at most MAX_BURST beats and streams them out through a FIFO.
//   clock, reset     : clock, synchronous active-high reset
//   launch           : start pulse, honoured only when idle
//   base_addr        : first byte address (beat aligned)
//   length           : number of words to fetch
//   busy             : transfer in progress
//   done             : one-cycle completion pulse
//   cycles           : busy-cycle count of the last transfer (saturating)
//   bus (master)     : memory request/read-beat port and output stream
module rd_stream
  import rd_stream_pkg::*;
#(
  parameter int unsigned MEM_LEN_BITS   = 8,
  parameter int unsigned MEM_ADDR_BITS  = 32,
  parameter int unsigned MEM_DATA_BITS  = 64,
  parameter int unsigned HOST_DATA_BITS = 32,
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned FIFO_DEPTH     = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      launch,
  input  logic [MEM_ADDR_BITS-1:0]  base_addr,
  input  logic [HOST_DATA_BITS-1:0] length,
  output logic                      busy,
  output logic                      done,
  output logic [HOST_DATA_BITS-1:0] cycles,
  rd_stream_if.master               bus
);

  localparam int unsigned BEAT_BYTES = MEM_DATA_BITS / 8;
  localparam int unsigned BW         = $clog2(MAX_BURST) + 1;
  localparam int unsigned CW         = fifo_cnt_bits(FIFO_DEPTH);

  state_e                    state_q, state_d;
  logic [MEM_ADDR_BITS-1:0]  addr_q, addr_d;
  logic [HOST_DATA_BITS-1:0] remain_q, remain_d;
  logic [BW-1:0]             beat_cnt_q, beat_cnt_d;
  logic                      req_valid_q, req_valid_d;
  logic [MEM_LEN_BITS-1:0]   req_len_q, req_len_d;
  logic [MEM_ADDR_BITS-1:0]  req_addr_q, req_addr_d;
  logic                      rd_ready_q, rd_ready_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [HOST_DATA_BITS-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [HOST_DATA_BITS-1:0] cycles_q, cycles_d;

  logic [BW-1:0]             beats_c;
  logic [CW-1:0]             free_c;
  logic [HOST_DATA_BITS-1:0] cyc_inc_c;
  logic                      beat_acc, drain_empty;

  logic                      fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]             fifo_count;
  logic [MEM_DATA_BITS-1:0]  fifo_rdata;

  rd_fifo #(
    .WIDTH (MEM_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (beat_acc),
    .wdata_i (bus.mem_rd_bits),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Burst size for the next request and the FIFO room it must fit into.
  always_comb begin
    if (remain_q < HOST_DATA_BITS'(MAX_BURST)) beats_c = BW'(remain_q);
    else                                       beats_c = BW'(MAX_BURST);
  end

  assign free_c    = CW'(FIFO_DEPTH) - fifo_count;
  assign beat_acc  = bus.mem_rd_valid && rd_ready_q;
  assign fifo_pop  = bus.out_ready && !fifo_empty;
  assign cyc_inc_c = (cyc_cnt_q == '1) ? cyc_cnt_q : cyc_cnt_q + HOST_DATA_BITS'(1);
  // Empty now, or the last word leaves this cycle.
  assign drain_empty = (fifo_count == '0) || ((fifo_count == CW'(1)) && fifo_pop);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    beat_cnt_d  = beat_cnt_q;
    req_valid_d = 1'b0;
    req_len_d   = req_len_q;
    req_addr_d  = req_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cycles_d    = cycles_q;
    cyc_cnt_d   = busy_q ? cyc_inc_c : cyc_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          if (length == '0) begin
            done_d   = 1'b1;
            cycles_d = '0;
          end else begin
            addr_d    = base_addr;
            remain_d  = length;
            cyc_cnt_d = '0;
            busy_d    = 1'b1;
            state_d   = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // Reserve FIFO room for the whole burst before issuing it.
        if (free_c >= CW'(beats_c)) begin
          req_valid_d = 1'b1;
          req_len_d   = MEM_LEN_BITS'(beats_c) - MEM_LEN_BITS'(1);
          req_addr_d  = addr_q;
          addr_d      = addr_q + MEM_ADDR_BITS'(beats_c) * MEM_ADDR_BITS'(BEAT_BYTES);
          remain_d    = remain_q - HOST_DATA_BITS'(beats_c);
          beat_cnt_d  = beats_c;
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_q - BW'(1);
          if (beat_cnt_q == BW'(1)) state_d = (remain_q != '0) ? ST_REQ : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_empty) begin
          done_d   = 1'b1;
          busy_d   = 1'b0;
          cycles_d = cyc_inc_c;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rd_ready_d = (state_d == ST_DATA);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      beat_cnt_q  <= '0;
      req_valid_q <= 1'b0;
      req_len_q   <= '0;
      req_addr_q  <= '0;
      rd_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cyc_cnt_q   <= '0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      beat_cnt_q  <= beat_cnt_d;
      req_valid_q <= req_valid_d;
      req_len_q   <= req_len_d;
      req_addr_q  <= req_addr_d;
      rd_ready_q  <= rd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cyc_cnt_q   <= cyc_cnt_d;
      cycles_q    <= cycles_d;
    end
  end

  // Room is reserved at request time, so an accepted beat never meets a full FIFO.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(beat_acc && fifo_full));

  assign bus.mem_req_valid  = req_valid_q;
  assign bus.mem_req_opcode = MEM_OP_RD;
  assign bus.mem_req_len    = req_len_q;
  assign bus.mem_req_addr   = req_addr_q;
  assign bus.mem_rd_ready   = rd_ready_q;
  assign bus.out_valid      = !fifo_empty;
  assign bus.out_data       = fifo_rdata;
  assign busy               = busy_q;
  assign done               = done_q;
  assign cycles             = cycles_q;

endmodule

// File: tb/tb_rd_stream.sv
// Bench for rd_stream: memory responder, transfer-level reference model and
// a per-cycle compare process, driven by directed transfers.
module tb_rd_stream;
  import rd_stream_pkg::*;

  localparam int LB = 8;
  localparam int AB = 32;
  localparam int DB = 64;
  localparam int HB = 32;
  localparam int MB = 16;
  localparam int FD = 32;

  typedef struct {
    logic [LB-1:0] len;
    logic [AB-1:0] addr;
  } req_t;

  logic          clock, reset, launch;
  logic [AB-1:0] base_addr;
  logic [HB-1:0] length;
  logic          busy, done;
  logic [HB-1:0] cycles;

  rd_stream_if #(.MEM_LEN_BITS(LB), .MEM_ADDR_BITS(AB), .MEM_DATA_BITS(DB)) bus ();

  rd_stream #(
    .MEM_LEN_BITS(LB), .MEM_ADDR_BITS(AB), .MEM_DATA_BITS(DB),
    .HOST_DATA_BITS(HB), .MAX_BURST(MB), .FIFO_DEPTH(FD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .launch    (launch),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .cycles    (cycles),
    .bus       (bus.master)
  );

  req_t          exp_req[$];
  req_t          req_log[$];
  logic [DB-1:0] exp_word[$];
  logic [AB-1:0] beat_q[$];

  int n_vec = 0, n_err = 0;
  int done_cnt = 0, push_cnt = 0, occ = 0, busy_cnt = 0;
  bit gap_en = 0, mem_flush = 0;

  function automatic logic [DB-1:0] mem_word(input logic [AB-1:0] a);
    return {a, ~a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_req(input string name, input int idx, input logic [LB-1:0] l, input logic [AB-1:0] a);
    if (idx < req_log.size()) begin
      chk({name, "_len"}, 64'(req_log[idx].len), 64'(l));
      chk({name, "_addr"}, 64'(req_log[idx].addr), 64'(a));
    end else begin
      chk({name, "_present"}, 64'(req_log.size()), 64'(idx + 1));
    end
  endtask

  // Reference: a transfer is split into MB-beat bursts, last one shorter.
  function automatic void expect_xfer(input logic [AB-1:0] base, input int len);
    req_t r;
    int n;
    for (int off = 0; off < len; off += MB) begin
      n = (len - off < MB) ? len - off : MB;
      r.len  = LB'(n - 1);
      r.addr = base + AB'(off * (DB / 8));
      exp_req.push_back(r);
    end
    for (int i = 0; i < len; i++) exp_word.push_back(mem_word(base + AB'(i * (DB / 8))));
  endfunction

  task automatic launch_xfer(input logic [AB-1:0] base, input int len);
    expect_xfer(base, len);
    req_log.delete();
    @(posedge clock); #1;
    launch = 1'b1; base_addr = base; length = HB'(len);
    @(posedge clock); #1;
    launch = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int d0;
    int k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < max_cyc) begin
      @(negedge clock);
      k++;
    end
    chk(name, 64'(done_cnt != d0), 64'(1));
    @(negedge clock);
    chk({name, "_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory responder: one burst at a time, beats held until accepted.
  initial begin
    bit            acc_s, req_s;
    logic [LB-1:0] rl;
    logic [AB-1:0] ra;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_bits  = '0;
    forever begin
      @(negedge clock);
      acc_s = bus.mem_rd_valid && bus.mem_rd_ready;
      req_s = bus.mem_req_valid;
      rl    = bus.mem_req_len;
      ra    = bus.mem_req_addr;
      @(posedge clock); #1;
      if (acc_s && beat_q.size() != 0) void'(beat_q.pop_front());
      if (req_s) for (int i = 0; i <= int'(rl); i++) beat_q.push_back(ra + AB'(i * (DB / 8)));
      if (mem_flush) beat_q.delete();
      if (beat_q.size() == 0) begin
        bus.mem_rd_valid = 1'b0;
      end else if (!bus.mem_rd_valid || acc_s) begin
        if (!gap_en || $urandom_range(0, 2) != 0) begin
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_bits  = mem_word(beat_q[0]);
        end else begin
          bus.mem_rd_valid = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare against the reference queues and occupancy model.
  initial begin
    req_t r, e;
    forever begin
      @(negedge clock);
      if (reset) begin
        occ = 0;
        busy_cnt = 0;
      end else begin
        chk("out_valid", 64'(bus.out_valid), 64'(occ != 0));
        if (bus.mem_req_valid) begin
          r.len  = bus.mem_req_len;
          r.addr = bus.mem_req_addr;
          req_log.push_back(r);
          chk("req_opcode", 64'(bus.mem_req_opcode), 64'(MEM_OP_RD));
          chk("req_space", 64'((FD - occ) >= int'(bus.mem_req_len) + 1), 64'(1));
          chk("req_expected", 64'(exp_req.size() != 0), 64'(1));
          if (exp_req.size() != 0) begin
            e = exp_req.pop_front();
            chk("req_len", 64'(r.len), 64'(e.len));
            chk("req_addr", 64'(r.addr), 64'(e.addr));
          end
        end
        if (bus.mem_rd_valid && bus.mem_rd_ready) begin
          occ++;
          push_cnt++;
          chk("fifo_bound", 64'(occ <= FD), 64'(1));
        end
        if (bus.out_valid && bus.out_ready) begin
          occ--;
          chk("word_expected", 64'(exp_word.size() != 0), 64'(1));
          if (exp_word.size() != 0) chk("out_data", 64'(bus.out_data), 64'(exp_word.pop_front()));
        end
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          chk("done_busy", 64'(busy), 64'(0));
          chk("cycles", 64'(cycles), 64'(busy_cnt));
          chk("done_words_left", 64'(exp_word.size()), 64'(0));
          chk("done_reqs_left", 64'(exp_req.size()), 64'(0));
          chk("done_fifo_empty", 64'(occ), 64'(0));
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    int p0, d0, k;
    reset = 1'b1; launch = 1'b0; base_addr = '0; length = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_cycles", 64'(cycles), 64'(0));
    chk("rst_req_valid", 64'(bus.mem_req_valid), 64'(0));
    chk("rst_rd_ready", 64'(bus.mem_rd_ready), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0;

    // Zero-length launch: done one cycle later, never busy, no request.
    launch_xfer(32'h0000_0500, 0);
    @(negedge clock);
    chk("len0_done", 64'(done), 64'(1));
    chk("len0_busy", 64'(busy), 64'(0));
    chk("len0_cycles", 64'(cycles), 64'(0));
    @(negedge clock);
    chk("len0_done_low", 64'(done), 64'(0));
    chk("len0_busy_low", 64'(busy), 64'(0));
    chk("len0_no_req", 64'(req_log.size()), 64'(0));

    // Five words, back-to-back beats, consumer always ready.
    bus.out_ready = 1'b1;
    gap_en = 0;
    launch_xfer(32'h0000_1000, 5);
    wait_done("len5_done", 200);
    chk("len5_nreq", 64'(req_log.size()), 64'(1));
    chk_req("len5_req0", 0, 8'd4, 32'h0000_1000);

    // Forty words with beat gaps: three bursts.
    gap_en = 1;
    launch_xfer(32'h0000_1000, 40);
    wait_done("len40_done", 1000);
    chk("len40_nreq", 64'(req_log.size()), 64'(3));
    chk_req("len40_req0", 0, 8'd15, 32'h0000_1000);
    chk_req("len40_req1", 1, 8'd15, 32'h0000_1080);
    chk_req("len40_req2", 2, 8'd7,  32'h0000_1100);

    // Consumer stalled: two bursts fill the FIFO, the third waits for room.
    gap_en = 0;
    bus.out_ready = 1'b0;
    p0 = push_cnt;
    launch_xfer(32'h0000_2000, 40);
    repeat (150) @(negedge clock);
    chk("stall_nreq", 64'(req_log.size()), 64'(2));
    chk("stall_beats", 64'(push_cnt - p0), 64'(32));
    chk("stall_out_valid", 64'(bus.out_valid), 64'(1));
    chk("stall_busy", 64'(busy), 64'(1));
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    wait_done("stall_done", 1000);
    chk_req("stall_req2", 2, 8'd7, 32'h0000_2100);

    // Launch while busy must be ignored.
    gap_en = 1;
    d0 = done_cnt;
    launch_xfer(32'h0000_3000, 20);
    repeat (8) @(posedge clock);
    #1;
    launch = 1'b1; base_addr = 32'h0000_9000; length = 32'd3;
    @(posedge clock); #1;
    launch = 1'b0;
    wait_done("relaunch_done", 1000);
    repeat (5) @(negedge clock);
    chk("relaunch_ndone", 64'(done_cnt - d0), 64'(1));
    chk("relaunch_nreq", 64'(req_log.size()), 64'(2));
    chk_req("relaunch_req1", 1, 8'd3, 32'h0000_3080);

    // Address wraps past the top of the address space.
    launch_xfer(32'hFFFF_FFC0, 20);
    wait_done("wrap_done", 1000);
    chk_req("wrap_req0", 0, 8'd15, 32'hFFFF_FFC0);
    chk_req("wrap_req1", 1, 8'd3,  32'h0000_0040);

    // Reset in the middle of a burst abandons the transfer.
    gap_en = 0;
    p0 = push_cnt;
    d0 = done_cnt;
    launch_xfer(32'h0000_5000, 10);
    k = 0;
    while (push_cnt - p0 < 3 && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("mid_three_beats", 64'(push_cnt - p0 >= 3), 64'(1));
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_cycles", 64'(cycles), 64'(0));
    chk("mid_rst_req_valid", 64'(bus.mem_req_valid), 64'(0));
    chk("mid_rst_rd_ready", 64'(bus.mem_rd_ready), 64'(0));
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    exp_req.delete();
    exp_word.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      chk("post_rst_rd_ready", 64'(bus.mem_rd_ready), 64'(0));
    end
    mem_flush = 1;
    @(posedge clock);
    @(negedge clock);
    mem_flush = 0;
    chk("post_rst_no_done", 64'(done_cnt), 64'(d0));

    // Fresh launch after the abandoned transfer.
    launch_xfer(32'h0000_6000, 3);
    wait_done("fresh_done", 200);
    chk("fresh_nreq", 64'(req_log.size()), 64'(1));
    chk_req("fresh_req0", 0, 8'd2, 32'h0000_6000);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
